qdr_cfg_ctrl: RTL and testbench

OPB-slave configuration and status block for a QDR SRAM controller, all in the OPB clock domain. Software issues a timed `qdr_reset` pulse to the QDR controller and polls its `phy_rdy` and `cal_fail` status through a small register window. It sits beside the QDR data-path arbiter on the configuration OPB bus.

---
 rtl/qdr_cfg_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_qdr_cfg_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qdr_cfg_ctrl.sv
`timescale 1ns/1ps
// qdr_cfg_ctrl: OPB slave register window that issues timed qdr_reset pulses and reports QDR PHY status.
// Build option QDR_CFG_STICKY_FAIL_EN: the cal_fail status bit becomes a sticky, write-1-to-clear flag.
module qdr_cfg_ctrl #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          RST_LEN_DEF  = 16
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic        phy_rdy,
  input  logic        cal_fail,
  output logic        qdr_reset
);

  localparam logic [7:0]  LEN_RST = 8'(RST_LEN_DEF);
  localparam logic [31:0] W_INFO  = 32'(C_OPB_AWIDTH ^ C_OPB_DWIDTH);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Bus fields re-ordered so that bit 0 is the LSB internally.
  logic [31:0] w_addr;
  logic [31:0] w_dat;
  logic [3:0]  w_be;
  assign w_addr = OPB_ABus;
  assign w_dat  = OPB_DBus;
  assign w_be   = OPB_BE;

  // Window test via 33-bit differences: the borrow bit flags addresses outside the range.
  logic [32:0] w_dlo;
  logic [32:0] w_dhi;
  logic [31:0] w_off;
  logic        w_hit;
  assign w_dlo = {1'b0, w_addr} - {1'b0, C_BASEADDR};
  assign w_dhi = {1'b0, C_HIGHADDR} - {1'b0, w_addr};
  assign w_off = w_dlo[31:0];
  assign w_hit = ~w_dlo[32] & ~w_dhi[32];

  logic r_phy_m, r_phy_s, r_cal_m, r_cal_s;
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_phy_m <= 1'b0;
      r_phy_s <= 1'b0;
      r_cal_m <= 1'b0;
      r_cal_s <= 1'b0;
    end else begin
      r_phy_m <= phy_rdy;
      r_phy_s <= r_phy_m;
      r_cal_m <= cal_fail;
      r_cal_s <= r_cal_m;
    end
  end

  state_t      r_state, w_state_nxt;
  logic        r_ack;
  logic        r_rnw;
  logic [1:0]  r_sel;
  logic [7:0]  r_wdat;
  logic        r_wbe0;
  logic [31:0] r_dbus;
  logic [31:0] w_rdata;
  logic        w_take;

  logic [7:0]  r_len;
  logic [15:0] r_rst_cnt;
  logic [7:0]  r_cnt;
  logic        r_qdr;
  logic        w_fail_bit;

  assign w_take = (r_state == ST_IDLE) & OPB_select & w_hit;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Stay in BUSY until select drops so a held select is acknowledged once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_take)      w_state_nxt = ST_BUSY;
      ST_BUSY: if (!OPB_select) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off[3:2])
      2'd0:    w_rdata = {29'd0, r_qdr, w_fail_bit, r_phy_s};
      2'd1:    w_rdata = {24'd0, r_len};
      2'd2:    w_rdata = {16'd0, r_rst_cnt};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_ack  <= 1'b0;
      r_rnw  <= 1'b1;
      r_sel  <= 2'd0;
      r_wdat <= 8'd0;
      r_wbe0 <= 1'b0;
      r_dbus <= 32'd0;
    end else begin
      r_ack  <= w_take;
      r_dbus <= (w_take & OPB_RNW) ? w_rdata : 32'd0;
      if (w_take) begin
        r_rnw  <= OPB_RNW;
        r_sel  <= w_off[3:2];
        r_wdat <= w_dat[7:0];
        r_wbe0 <= w_be[0];
      end
    end
  end

  // Writes commit on the edge that ends the ack cycle.
  logic w_wr, w_wr_ctrl, w_start, w_clr, w_len_we;
  assign w_wr      = r_ack & ~r_rnw;
  assign w_wr_ctrl = w_wr & (r_sel == 2'd0) & r_wbe0;
  assign w_start   = w_wr_ctrl & r_wdat[0];
  assign w_clr     = w_wr_ctrl & r_wdat[1];
  assign w_len_we  = w_wr & (r_sel == 2'd1) & r_wbe0;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_len     <= LEN_RST;
      r_rst_cnt <= 16'd0;
    end else begin
      if (w_len_we) r_len <= r_wdat;
      if (w_start)  r_rst_cnt <= r_rst_cnt + 16'd1;
    end
  end

  logic [7:0] w_load;
  logic [7:0] w_cnt_nxt;
  assign w_load = (r_len == 8'd0) ? 8'd1 : r_len;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_start)            w_cnt_nxt = w_load;
    else if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
  end

  // qdr_reset is registered from the next counter value so it stays glitch-free.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_cnt <= LEN_RST;
      r_qdr <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_qdr <= (w_cnt_nxt != 8'd0);
    end
  end

`ifdef QDR_CFG_STICKY_FAIL_EN
  logic r_fail;
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)   r_fail <= 1'b0;
    else if (r_cal_s) r_fail <= 1'b1;
    else if (w_clr)   r_fail <= 1'b0;
  end
  assign w_fail_bit = r_fail;
`else
  assign w_fail_bit = r_cal_s;
`endif

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign qdr_reset  = r_qdr;

  logic w_unused;
  assign w_unused = ^{OPB_seqAddr, w_off[31:4], w_off[1:0], w_dat[31:8], w_be[3:1],
                      w_clr, W_INFO[0]};

endmodule

// File: tb/tb_qdr_cfg_ctrl.sv
`timescale 1ns/1ps
// Directed bench for qdr_cfg_ctrl: pulse-timing model checked every cycle plus literal spot checks.
module tb_qdr_cfg_ctrl;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] HIGH = 32'h0000_100F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be_i = '0;
  logic [0:31] wdat = '0;
  logic        rnw = 1'b1;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        ack, err_ack, retry, tout_sup;
  logic        phy_rdy = 1'b0;
  logic        cal_fail = 1'b0;
  logic        qdr_reset;

  always #5 clk = ~clk;

  qdr_cfg_ctrl #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32),
                 .C_OPB_DWIDTH(32), .RST_LEN_DEF(16)) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_i), .OPB_DBus(wdat),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(ack), .Sl_errAck(err_ack), .Sl_retry(retry), .Sl_toutSup(tout_sup),
    .phy_rdy(phy_rdy), .cal_fail(cal_fail), .qdr_reset(qdr_reset));

  int n_tests = 0, n_fail = 0;
  int cyc = 0, pulse_end = 0, hi_cnt = 0, ack_cnt = 0;
  bit live = 0;
  logic ack_q = 1'b0;
  int len_m = 16, cnt_m = 0;
  bit fail_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic fail_exp();
`ifdef QDR_CFG_STICKY_FAIL_EN
    return fail_m;
`else
    return cal_fail;
`endif
  endfunction

  // Model: qdr_reset is high exactly for samples with cyc < pulse_end.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      chk("rst_qdr_reset", {31'd0, qdr_reset}, 32'd1);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_dbus", sl_dbus, 32'd0);
    end else if (live) begin
      chk("qdr_reset", {31'd0, qdr_reset}, {31'd0, cyc < pulse_end});
      if (qdr_reset) hi_cnt++;
      if (!ack) chk("dbus_idle", sl_dbus, 32'd0);
      chk("ack_one_cycle", {31'd0, ack & ack_q}, 32'd0);
      chk("tied_zero", {29'd0, err_ack, retry, tout_sup}, 32'd0);
      if (ack) ack_cnt++;
    end
    ack_q = ack;
  end

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse_end = cyc + 1 + 16;
    hi_cnt = 0;
    live = 1;
  endtask

  task automatic opb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    abus = BASE + {28'd0, off}; wdat = d; be_i = be; rnw = 1'b0; sel = 1'b1;
    @(negedge clk);
    chk("wr_ack", {31'd0, ack}, 32'd1);
    sel = 1'b0;
    if (off[3:2] == 2'd0 && be[0] && d[0]) begin
      pulse_end = cyc + 1 + ((len_m == 0) ? 1 : len_m);
      cnt_m = (cnt_m + 1) & 16'hFFFF;
    end
    if (off[3:2] == 2'd0 && be[0] && d[1]) fail_m = 0;
    if (off[3:2] == 2'd1 && be[0]) len_m = int'(d[7:0]);
    @(negedge clk);
    chk("wr_ack_drop", {31'd0, ack}, 32'd0);
  endtask

  task automatic opb_read(input logic [3:0] off, input string name, output logic [31:0] got);
    logic [31:0] exp_q;
    @(negedge clk);
    abus = BASE + {28'd0, off}; wdat = 32'hDEAD_BEEF; be_i = 4'hF; rnw = 1'b1; sel = 1'b1;
    case (off[3:2])
      2'd0:    exp_q = {29'd0, (cyc < pulse_end), fail_exp(), phy_rdy};
      2'd1:    exp_q = 32'(len_m);
      2'd2:    exp_q = 32'(cnt_m);
      default: exp_q = 32'd0;
    endcase
    @(negedge clk);
    chk({name, "_ack"}, {31'd0, ack}, 32'd1);
    chk(name, sl_dbus, exp_q);
    got = sl_dbus;
    sel = 1'b0;
    @(negedge clk);
    chk({name, "_ack_drop"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic miss(input logic [31:0] addr);
    int a0;
    @(negedge clk);
    a0 = ack_cnt;
    abus = addr; rnw = 1'b1; sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("miss_ack", {31'd0, ack}, 32'd0);
    end
    sel = 1'b0;
    chk("miss_ack_count", 32'(ack_cnt - a0), 32'd0);
  endtask

  logic [31:0] got;

  initial begin
    phy_rdy = 1'b1;
    repeat (3) @(posedge clk);
    release_reset();
    repeat (22) @(negedge clk);
    chk("poweron_pulse_len", 32'(hi_cnt), 32'd16);
    opb_read(4'h0, "status_poweron", got);
    chk("status_poweron_lit", got, 32'h0000_0001);
    opb_read(4'h8, "rst_cnt_init", got);
    chk("rst_cnt_init_lit", got, 32'd0);

    opb_write(4'h4, 32'd5, 4'hF);
    hi_cnt = 0;
    opb_write(4'h0, 32'd1, 4'hF);
    repeat (10) @(negedge clk);
    chk("pulse5_len", 32'(hi_cnt), 32'd5);
    opb_read(4'h8, "rst_cnt_1", got);
    chk("rst_cnt_1_lit", got, 32'd1);
    opb_read(4'h4, "rst_len_5", got);
    chk("rst_len_5_lit", got, 32'd5);
    opb_read(4'h7, "rst_len_lowbits", got);

    opb_write(4'h4, 32'd0, 4'hF);
    hi_cnt = 0;
    opb_write(4'h0, 32'd1, 4'hF);
    repeat (6) @(negedge clk);
    chk("pulse0_len", 32'(hi_cnt), 32'd1);
    opb_read(4'h4, "rst_len_0", got);

    opb_write(4'h4, 32'd5, 4'hF);
    hi_cnt = 0;
    opb_write(4'h0, 32'd1, 4'hF);
    opb_write(4'h0, 32'd1, 4'hF);
    repeat (12) @(negedge clk);
    chk("restart_len", 32'(hi_cnt), 32'd8);
    opb_read(4'h8, "rst_cnt_4", got);
    chk("rst_cnt_4_lit", got, 32'd4);

    hi_cnt = 0;
    opb_write(4'h0, 32'd1, 4'h0);
    opb_write(4'h0, 32'd1, 4'hE);
    repeat (6) @(negedge clk);
    chk("be0_no_pulse", 32'(hi_cnt), 32'd0);
    opb_read(4'h8, "rst_cnt_be0", got);
    chk("rst_cnt_be0_lit", got, 32'd4);

    @(negedge clk);
    cal_fail = 1'b1;
    fail_m = 1;
    @(negedge clk);
    cal_fail = 1'b0;
    repeat (4) @(negedge clk);
    opb_read(4'h0, "status_cal", got);
`ifdef QDR_CFG_STICKY_FAIL_EN
    chk("status_cal_lit", got, 32'h0000_0003);
`else
    chk("status_cal_lit", got, 32'h0000_0001);
`endif
    opb_read(4'h0, "status_cal_again", got);
    opb_write(4'h0, 32'd2, 4'hF);
    opb_read(4'h0, "status_cleared", got);
    chk("status_cleared_lit", got, 32'h0000_0001);

    opb_read(4'hF, "window_top", got);
    opb_read(4'hC, "reg_c", got);
    miss(BASE - 32'd1);
    miss(HIGH + 32'd1);
    miss(32'h0000_2000);

    begin
      int a0;
      @(negedge clk);
      a0 = ack_cnt;
      abus = BASE + 32'h8; rnw = 1'b1; sel = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("hold_ack", {31'd0, ack}, {31'd0, i == 0});
        if (i == 0) chk("hold_data", sl_dbus, 32'(cnt_m));
      end
      sel = 1'b0;
      @(negedge clk);
      chk("hold_ack_after", {31'd0, ack}, 32'd0);
      chk("hold_one_ack", 32'(ack_cnt - a0), 32'd1);
    end

    @(negedge clk);
    abus = BASE; rnw = 1'b1; sel = 1'b1;
    @(negedge clk);
    chk("mid_ack_pre", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    live = 0;
    sel = 1'b0;
    #1;
    chk("mid_ack_abort", {31'd0, ack}, 32'd0);
    chk("mid_dbus_abort", sl_dbus, 32'd0);
    len_m = 16; cnt_m = 0; fail_m = 0;
    repeat (2) @(posedge clk);
    release_reset();
    repeat (20) @(negedge clk);
    chk("rereset_pulse_len", 32'(hi_cnt), 32'd16);
    opb_read(4'h4, "rst_len_rereset", got);
    chk("rst_len_rereset_lit", got, 32'd16);
    opb_read(4'h8, "rst_cnt_rereset", got);
    chk("rst_cnt_rereset_lit", got, 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end
endmodule
